// File: rtl/uart_framebuffer_pkg.sv
// Shared definitions for the UART-fed framebuffer: header codes, LIT length mask
// and the packet decoder state encoding.
package uart_framebuffer_pkg;

   localparam logic [7:0] HDR_RUN_MAX  = 8'h7F;
   localparam logic [7:0] HDR_LIT_MAX  = 8'hBF;
   localparam logic [7:0] HDR_ADDR     = 8'hC0;
   localparam logic [7:0] HDR_FILL     = 8'hC1;
   localparam logic [7:0] LIT_LEN_MASK = 8'h3F;

   typedef enum logic [2:0] {
      S_IDLE, S_RUN_VAL, S_RUN_WR, S_LIT, S_ADDR_HI, S_ADDR_LO, S_FILL_VAL, S_FILL_WR
   } fb_state_e;

   function automatic logic [7:0] lit_count(input logic [7:0] hdr);
      return (hdr & LIT_LEN_MASK) + 8'd1;
   endfunction

endpackage

// File: rtl/uart_framebuffer_ram.sv
// Simple dual-port DEPTHx8 RAM: one write port, one registered read port,
// read-before-write on a same-address collision. No reset so it maps to BRAM.
module uart_framebuffer_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/uart_framebuffer.sv
// Framebuffer fed by a UART byte stream: decodes RUN/LIT/ADDR/FILL packets into a
// COLS x PAGES byte memory and serves (page, column) reads with a one-cycle ack.
module uart_framebuffer
   import uart_framebuffer_pkg::*;
#(
   parameter int COLS  = 128,
   parameter int PAGES = 8
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     rx_valid,
   input  logic [7:0]                               rx_byte,
   input  logic                                     rd_req,
   input  logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0] rd_page,
   input  logic [$clog2(COLS)-1:0]                  rd_col,
   output logic [7:0]                               rd_data,
   output logic                                     rd_ack,
   output logic                                     busy,
   output logic                                     frame_done,
   output logic                                     overrun,
   output logic                                     proto_err,
   input  logic                                     clr_err
);

   localparam int DEPTH = COLS * PAGES;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(COLS);
   localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   fb_state_e     state_q;
   logic [AW-1:0] wp_q;
   logic [7:0]    cnt_q, val_q, hi_q;
   logic          lit_we_q, frame_done_q, overrun_q, proto_err_q, rd_ack_q, rd_oob_q;

   logic          we, busy_w, rd_in;
   logic [16:0]   addr_req;
   logic [AW-1:0] raddr;
   logic [7:0]    ram_rdata;

   assign busy_w   = (state_q == S_RUN_WR) || (state_q == S_FILL_WR);
   // A LIT byte is registered and written one cycle later; it never overlaps a burst.
   assign we       = busy_w || lit_we_q;
   assign addr_req = {1'b0, hi_q, rx_byte};
   assign rd_in    = ({1'b0, rd_col} < (CW+1)'(COLS)) && ({1'b0, rd_page} < (PW+1)'(PAGES));
   assign raddr    = rd_in ? AW'(32'(rd_page) * COLS + 32'(rd_col)) : '0;

   uart_framebuffer_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wp_q),
      .wdata_i (val_q),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wp_q         <= '0;
         cnt_q        <= '0;
         val_q        <= '0;
         hi_q         <= '0;
         lit_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         proto_err_q  <= 1'b0;
         rd_ack_q     <= 1'b0;
         rd_oob_q     <= 1'b0;
      end else begin
         lit_we_q     <= 1'b0;
         frame_done_q <= we && (wp_q == LAST);
         rd_ack_q     <= rd_req;
         rd_oob_q     <= !rd_in;
         if (we) wp_q <= (wp_q == LAST) ? '0 : wp_q + AW'(1);
         if (clr_err) begin
            overrun_q   <= 1'b0;
            proto_err_q <= 1'b0;
         end
         if (rx_valid && busy_w) overrun_q <= 1'b1;
         case (state_q)
            S_IDLE: if (rx_valid) begin
               if (rx_byte <= HDR_RUN_MAX) begin
                  cnt_q   <= rx_byte + 8'd1;
                  state_q <= S_RUN_VAL;
               end else if (rx_byte <= HDR_LIT_MAX) begin
                  cnt_q   <= lit_count(rx_byte);
                  state_q <= S_LIT;
               end else if (rx_byte == HDR_ADDR) begin
                  state_q <= S_ADDR_HI;
               end else if (rx_byte == HDR_FILL) begin
                  state_q <= S_FILL_VAL;
               end
            end
            S_RUN_VAL: if (rx_valid) begin
               val_q   <= rx_byte;
               state_q <= S_RUN_WR;
            end
            S_RUN_WR: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= S_IDLE;
            end
            S_LIT: if (rx_valid) begin
               val_q    <= rx_byte;
               lit_we_q <= 1'b1;
               cnt_q    <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= S_IDLE;
            end
            S_ADDR_HI: if (rx_valid) begin
               hi_q    <= rx_byte;
               state_q <= S_ADDR_LO;
            end
            S_ADDR_LO: if (rx_valid) begin
               if (addr_req >= 17'(DEPTH)) begin
                  wp_q        <= '0;
                  proto_err_q <= 1'b1;
               end else begin
                  wp_q <= AW'(addr_req);
               end
               state_q <= S_IDLE;
            end
            S_FILL_VAL: if (rx_valid) begin
               val_q   <= rx_byte;
               wp_q    <= '0;
               state_q <= S_FILL_WR;
            end
            S_FILL_WR: if (wp_q == LAST) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rd_data    = (rd_ack_q && !rd_oob_q) ? ram_rdata : 8'h00;
   assign rd_ack     = rd_ack_q;
   assign busy       = busy_w;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
   assign proto_err  = proto_err_q;

endmodule
